// File: rtl/imem_sync_prog.sv
`default_nettype none
// ============================================================================
// Module   : imem_sync_prog
// Purpose  : Synchronous instruction memory for the pipelined MIPS IF stage.
//            Registered word fetch indexed by pc, with IF-stall hold and
//            misaligned/out-of-range fault flagging. A loader port lets a
//            program be written at run time through a req/valid/ready
//            handshake (IDLE -> LOAD -> DRAIN -> IDLE).
// Ports    : clk, reset (sync, active-low)
//            fetch_en, pc            -> instruction, instr_valid, fetch_fault
//            prog_req, prog_valid, prog_addr, prog_data
//                                    -> prog_ready, prog_done, prog_count
//            [IMEM_PARITY_EN] prog_bad_par -> parity_err
// Options  : define IMEM_PARITY_EN to store one even-parity bit per word,
//            with error injection on write and checking on fetch.
// Revision : 1.0 - initial release
// ============================================================================
module imem_sync_prog #(
    parameter int          ADDR_W    = 8,
    parameter int          DATA_W    = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter              INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic [31:0]       pc,
    output logic [DATA_W-1:0] instruction,
    output logic              instr_valid,
    output logic              fetch_fault,
`ifdef IMEM_PARITY_EN
    input  logic              prog_bad_par,
    output logic              parity_err,
`endif
    input  logic              prog_req,
    input  logic              prog_valid,
    output logic              prog_ready,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_done,
    output logic [ADDR_W:0]   prog_count
);

    localparam int              c_depth     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] c_count_max = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [DATA_W-1:0] c_nop     = '0;

    // Byte span of the array; 33 bits so the upper bound cannot wrap.
    localparam logic [32:0] c_span = 33'd4 << ADDR_W;

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_load  = 2'd1;
    localparam logic [1:0] c_drain = 2'd2;

    logic [DATA_W-1:0] r_mem [c_depth];
`ifdef IMEM_PARITY_EN
    logic              r_par [c_depth];
`endif

    logic [1:0]        r_state;
    logic [32:0]       w_off;
    logic              w_bad_fetch;
    logic [ADDR_W-1:0] w_idx;
    logic              w_wr;

    // Offset from the base with a borrow bit: bit 32 set means pc < BASE_ADDR.
    // Any offset at or above the span is beyond the last word.
    assign w_off       = {1'b0, pc} - {1'b0, BASE_ADDR};
    assign w_bad_fetch = (pc[1:0] != 2'b00) || (w_off >= c_span);
    assign w_idx       = w_off[ADDR_W+1:2];

    // Gated by reset so a beat presented during a mid-load reset is dropped.
    assign w_wr = reset && (r_state == c_load) && prog_valid && prog_ready;

    // Storage array: never reset, so contents survive a reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[prog_addr] <= prog_data;
`ifdef IMEM_PARITY_EN
            r_par[prog_addr] <= (^prog_data) ^ prog_bad_par;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= c_idle;
            instruction <= c_nop;
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
            prog_ready  <= 1'b0;
            prog_done   <= 1'b0;
            prog_count  <= '0;
`ifdef IMEM_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end else begin
            prog_done <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (prog_req) begin
                        // Loader wins over a simultaneous fetch.
                        r_state     <= c_load;
                        prog_ready  <= 1'b1;
                        prog_count  <= '0;
                        instruction <= c_nop;
                        instr_valid <= 1'b0;
                        fetch_fault <= 1'b0;
`ifdef IMEM_PARITY_EN
                        parity_err  <= 1'b0;
`endif
                    end else if (fetch_en) begin
                        if (w_bad_fetch) begin
                            instruction <= c_nop;
                            instr_valid <= 1'b0;
                            fetch_fault <= 1'b1;
`ifdef IMEM_PARITY_EN
                            parity_err  <= 1'b0;
`endif
                        end else begin
                            fetch_fault <= 1'b0;
`ifdef IMEM_PARITY_EN
                            if ((^r_mem[w_idx]) != r_par[w_idx]) begin
                                instruction <= c_nop;
                                instr_valid <= 1'b0;
                                parity_err  <= 1'b1;
                            end else begin
                                instruction <= r_mem[w_idx];
                                instr_valid <= 1'b1;
                                parity_err  <= 1'b0;
                            end
`else
                            instruction <= r_mem[w_idx];
                            instr_valid <= 1'b1;
`endif
                        end
                    end
                end
                c_load: begin
                    instruction <= c_nop;
                    instr_valid <= 1'b0;
                    fetch_fault <= 1'b0;
`ifdef IMEM_PARITY_EN
                    parity_err  <= 1'b0;
`endif
                    if (w_wr && (prog_count != c_count_max))
                        prog_count <= prog_count + 1'b1;
                    if (!prog_req) begin
                        r_state    <= c_drain;
                        prog_ready <= 1'b0;
                        prog_done  <= 1'b1;
                    end
                end
                c_drain: begin
                    r_state     <= c_idle;
                    instruction <= c_nop;
                    instr_valid <= 1'b0;
                    fetch_fault <= 1'b0;
`ifdef IMEM_PARITY_EN
                    parity_err  <= 1'b0;
`endif
                end
                default: begin
                    r_state    <= c_idle;
                    prog_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_sync_prog.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_imem_sync_prog
// Purpose  : Self-checking bench for imem_sync_prog: table of fetch vectors
//            plus directed load-session, mid-load reset and saturation runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_sync_prog;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        fetch_fault;
    logic        prog_req;
    logic        prog_valid;
    logic        prog_ready;
    logic [7:0]  prog_addr;
    logic [31:0] prog_data;
    logic        prog_done;
    logic [8:0]  prog_count;
`ifdef IMEM_PARITY_EN
    logic        prog_bad_par;
    logic        parity_err;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    imem_sync_prog dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_en    (fetch_en),
        .pc          (pc),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .fetch_fault (fetch_fault),
`ifdef IMEM_PARITY_EN
        .prog_bad_par(prog_bad_par),
        .parity_err  (parity_err),
`endif
        .prog_req    (prog_req),
        .prog_valid  (prog_valid),
        .prog_ready  (prog_ready),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_done   (prog_done),
        .prog_count  (prog_count)
    );

    typedef struct {
        logic        en;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic        fault;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled there too.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] a, input logic [31:0] d);
        prog_valid = 1'b1;
        prog_addr  = a;
        prog_data  = d;
        tick();
        prog_valid = 1'b0;
    endtask

    task automatic fetch(input string name, input logic [31:0] a, input logic [31:0] exp_i,
                         input logic exp_v, input logic exp_f);
        fetch_en = 1'b1;
        pc       = a;
        tick();
        chk({name, ".instr"}, instruction, exp_i);
        chk({name, ".valid"}, {31'b0, instr_valid}, {31'b0, exp_v});
        chk({name, ".fault"}, {31'b0, fetch_fault}, {31'b0, exp_f});
    endtask

    // Closes a load session and checks the single done pulse and final count.
    task automatic end_session(input string name, input logic [8:0] exp_cnt);
        prog_req = 1'b0;
        tick();
        chk({name, ".done"}, {31'b0, prog_done}, 32'd1);
        chk({name, ".ready_off"}, {31'b0, prog_ready}, 32'd0);
        chk({name, ".count"}, {23'b0, prog_count}, {23'b0, exp_cnt});
        tick();
        chk({name, ".done_once"}, {31'b0, prog_done}, 32'd0);
        chk({name, ".count_hold"}, {23'b0, prog_count}, {23'b0, exp_cnt});
    endtask

    initial begin
        reset = 1'b0; fetch_en = 1'b0; pc = '0;
        prog_req = 1'b0; prog_valid = 1'b0; prog_addr = '0; prog_data = '0;
`ifdef IMEM_PARITY_EN
        prog_bad_par = 1'b0;
`endif
        //                en    pc             instr          v     f
        vecs[0]  = '{1'b1, 32'h0000_0000, 32'h3c01_0000, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 32'h0000_0004, 32'h3430_0000, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0008, 32'h2002_000a, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 32'h0000_000c, 32'h2002_000a, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_000c, 32'h2002_000a, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_000c, 32'h2002_000a, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 32'h0000_0006, 32'h0000_0000, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 32'h0000_000c, 32'h2003_000b, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 32'h0000_0400, 32'h0000_0000, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 32'h0000_0004, 32'h3430_0000, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 32'hffff_fffc, 32'h0000_0000, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 32'h0000_0401, 32'h0000_0000, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 32'h0000_0000, 32'h3c01_0000, 1'b1, 1'b0};

        // Reset state.
        tick(); tick();
        chk("rst.instr", instruction, 32'h0);
        chk("rst.valid", {31'b0, instr_valid}, 32'd0);
        chk("rst.fault", {31'b0, fetch_fault}, 32'd0);
        chk("rst.ready", {31'b0, prog_ready}, 32'd0);
        chk("rst.done",  {31'b0, prog_done}, 32'd0);
        chk("rst.count", {23'b0, prog_count}, 32'd0);
        reset = 1'b1;

        // Load the base program through the loader port.
        prog_req = 1'b1;
        tick();
        chk("s0.ready_on", {31'b0, prog_ready}, 32'd1);
        beat(8'd0, 32'h3c01_0000);
        beat(8'd1, 32'h3430_0000);
        beat(8'd2, 32'h2002_000a);
        beat(8'd3, 32'h2003_000b);
        end_session("s0", 9'd4);

        // Table-driven fetch/stall/fault vectors.
        for (int i = 0; i < 14; i++) begin
            fetch_en = vecs[i].en;
            pc       = vecs[i].pc;
            tick();
            chk($sformatf("vec%0d.instr", i), instruction, vecs[i].instr);
            chk($sformatf("vec%0d.valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].valid});
            chk($sformatf("vec%0d.fault", i), {31'b0, fetch_fault}, {31'b0, vecs[i].fault});
        end

        // Loader request and fetch in the same cycle: no fetch, enter LOAD.
        fetch_en = 1'b1;
        pc       = 32'h4;
        prog_req = 1'b1;
        tick();
        fetch_en = 1'b0;
        chk("s1.collide_instr", instruction, 32'h0);
        chk("s1.collide_valid", {31'b0, instr_valid}, 32'd0);
        chk("s1.ready_on", {31'b0, prog_ready}, 32'd1);
        chk("s1.count_clr", {23'b0, prog_count}, 32'd0);
        beat(8'd0, 32'h2008_0005);
        beat(8'd1, 32'h2009_0007);
        beat(8'd2, 32'h0109_5020);
        end_session("s1", 9'd3);
        fetch("s1.f0", 32'h0, 32'h2008_0005, 1'b1, 1'b0);
        fetch("s1.f4", 32'h4, 32'h2009_0007, 1'b1, 1'b0);
        fetch("s1.f8", 32'h8, 32'h0109_5020, 1'b1, 1'b0);

        // Reset in the middle of a load session: written beat is kept.
        fetch_en = 1'b0;
        prog_req = 1'b1;
        tick();
        beat(8'd0, 32'h1111_2222);
        prog_req = 1'b0;
        reset    = 1'b0;
        tick();
        chk("mid.ready", {31'b0, prog_ready}, 32'd0);
        chk("mid.done",  {31'b0, prog_done}, 32'd0);
        reset = 1'b1;
        tick();
        chk("mid.done_after", {31'b0, prog_done}, 32'd0);
        fetch("mid.f0", 32'h0, 32'h1111_2222, 1'b1, 1'b0);
        fetch("mid.f4", 32'h4, 32'h2009_0007, 1'b1, 1'b0);

`ifdef IMEM_PARITY_EN
        fetch_en = 1'b0;
        prog_req = 1'b1;
        tick();
        prog_bad_par = 1'b1;
        beat(8'd5, 32'h1234_5678);
        prog_bad_par = 1'b0;
        beat(8'd6, 32'h0000_0007);
        end_session("par", 9'd2);
        fetch("par.f14", 32'h14, 32'h0, 1'b0, 1'b0);
        chk("par.err_set", {31'b0, parity_err}, 32'd1);
        fetch("par.f18", 32'h18, 32'h0000_0007, 1'b1, 1'b0);
        chk("par.err_clr", {31'b0, parity_err}, 32'd0);
`endif

        // Count saturation: 258 beats, count must stop at 256.
        fetch_en = 1'b0;
        prog_req = 1'b1;
        tick();
        for (int i = 0; i < 258; i++) beat(i[7:0], 32'(i));
        end_session("sat", 9'd256);
        fetch("sat.f4", 32'h4, 32'h0000_0101, 1'b1, 1'b0);
        fetch("sat.f8", 32'h8, 32'h0000_0002, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
